// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared constants and state encoding for the 8b serial link
package sp_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sp_state_e;

endpackage

// File: rtl/serial_paralelo.sv
// rtl/serial_paralelo.sv - serial link receiver: comma alignment, lock and byte delivery
// Optional macro SP_COMMA_CNT_EN adds comma_cnt_out, a saturating count of commas seen while locked.
module serial_paralelo
  import sp_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = sp_pkg::COMMA,
  parameter int                COMMA_LOCK = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              serial_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
`ifdef SP_COMMA_CNT_EN
  ,
  output logic [7:0]        comma_cnt_out
`endif
);

  localparam logic [4:0] LOCK_N = 5'(COMMA_LOCK);

  sp_state_e         r_state, w_state_nxt;
  logic [BYTE_W-1:0] r_shreg;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]        r_comma_cnt, w_comma_cnt_nxt;
  logic [BYTE_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_strobe, w_strobe_nxt;
  logic              r_active, w_active_nxt;

  logic [BYTE_W-1:0] w_next_byte;
  logic              w_is_comma;
  logic              w_boundary;
  logic [4:0]        w_comma_inc;

  assign w_next_byte = {r_shreg[BYTE_W-2:0], serial_in};
  assign w_is_comma  = (w_next_byte == COMMA);
  assign w_boundary  = (r_bit_cnt == 3'd7);
  assign w_comma_inc = {1'b0, r_comma_cnt} + 5'd1;

  always_ff @(posedge clk_32f) begin
    if (reset) r_state <= SEARCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt + 3'd1;
    w_comma_cnt_nxt = r_comma_cnt;
    w_data_nxt      = r_data;
    w_valid_nxt     = r_valid;
    w_strobe_nxt    = 1'b0;
    w_active_nxt    = r_active;
    case (r_state)
      SEARCH: begin
        if (w_is_comma) begin
          w_bit_cnt_nxt   = 3'd0;
          w_comma_cnt_nxt = 4'd1;
          if (COMMA_LOCK == 1) begin
            w_state_nxt  = LOCKED;
            w_active_nxt = 1'b1;
          end else begin
            w_state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (w_boundary) begin
          if (w_is_comma) begin
            w_comma_cnt_nxt = w_comma_inc[3:0];
            if (w_comma_inc == LOCK_N) begin
              w_state_nxt  = LOCKED;
              w_active_nxt = 1'b1;
            end
          end else begin
            w_state_nxt     = SEARCH;
            w_comma_cnt_nxt = 4'd0;
          end
        end
      end
      LOCKED: begin
        // No loss-of-lock path: only reset leaves this state.
        if (w_boundary) begin
          w_strobe_nxt = 1'b1;
          if (w_is_comma) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_next_byte;
            w_valid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_shreg     <= '0;
      r_bit_cnt   <= 3'd0;
      r_comma_cnt <= 4'd0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_strobe    <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_shreg     <= w_next_byte;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_strobe    <= w_strobe_nxt;
      r_active    <= w_active_nxt;
    end
  end

  assign data_out    = r_data;
  assign valid_out   = r_valid;
  assign byte_strobe = r_strobe;
  assign active      = r_active;

`ifdef SP_COMMA_CNT_EN
  logic [7:0] r_comma_total;
  logic       w_locked_comma;

  assign w_locked_comma = (r_state == LOCKED) && w_boundary && w_is_comma;

  always_ff @(posedge clk_32f) begin
    if (reset)                                         r_comma_total <= 8'h00;
    else if (w_locked_comma && r_comma_total != 8'hFF) r_comma_total <= r_comma_total + 8'h01;
  end

  assign comma_cnt_out = r_comma_total;
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// tb/tb_serial_paralelo.sv - self-checking bench for serial_paralelo with a byte scoreboard
module tb_serial_paralelo;
  import sp_pkg::*;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
`ifdef SP_COMMA_CNT_EN
  logic [7:0] comma_cnt_out;
`endif

  serial_paralelo dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
`ifdef SP_COMMA_CNT_EN
    ,
    .comma_cnt_out (comma_cnt_out)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  int         n_checks  = 0;
  int         n_err     = 0;
  int         n_strobes = 0;
  int         n_pushed  = 0;
  logic [8:0] sb_q[$];
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected byte.
  always @(negedge clk_32f) begin
    logic [8:0] e;
    if (byte_strobe === 1'b1) begin
      n_strobes++;
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {31'd0, byte_strobe}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
        check("valid_out", {31'd0, valid_out}, {31'd0, e[8]});
      end
    end
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit locked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (locked) begin
      check("strobe_at_lsb", {31'd0, byte_strobe}, 32'd1);
      if (b != COMMA) exp_data = b;
      sb_q.push_back({(b != COMMA), exp_data});
      n_pushed++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    serial_in = 1'b0;
    repeat (3) @(posedge clk_32f);
    #1;
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_strobe", {31'd0, byte_strobe}, 32'd0);
    reset = 1'b0;

    repeat (40) send_bit(1'b0);
    check("idle_active", {31'd0, active}, 32'd0);
    check("idle_valid", {31'd0, valid_out}, 32'd0);
    check("idle_data", {24'd0, data_out}, 32'd0);
    check("idle_strobes", n_strobes, 32'd0);

    // Lock from a 3-bit offset.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_byte(COMMA, 0);
    send_byte(COMMA, 0);
    send_byte(COMMA, 0);
    check("lock_after3", {31'd0, active}, 32'd0);
    send_byte(COMMA, 0);
    check("lock_after4", {31'd0, active}, 32'd1);
    send_byte(COMMA, 1);
    send_byte(COMMA, 1);

    send_byte(8'hA5, 1);
    send_byte(8'h3C, 1);
    send_byte(COMMA, 1);
    send_bit(1'b1);
    check("held_data", {24'd0, data_out}, 32'h3C);
    check("held_valid", {31'd0, valid_out}, 32'd0);

    // Reset mid-byte while locked.
    send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    check("mid_rst_active", {31'd0, active}, 32'd0);
    check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    check("mid_rst_data", {24'd0, data_out}, 32'd0);
    reset    = 1'b0;
    exp_data = 8'h00;

    // Broken comma run, then a clean relock.
    send_byte(COMMA, 0);
    send_byte(COMMA, 0);
    send_byte(8'h55, 0);
    check("break_active", {31'd0, active}, 32'd0);
    send_byte(COMMA, 0);
    send_byte(COMMA, 0);
    send_byte(COMMA, 0);
    check("relock_after3", {31'd0, active}, 32'd0);
    send_byte(COMMA, 0);
    check("relock_after4", {31'd0, active}, 32'd1);
    send_byte(8'h7E, 1);
    send_byte(COMMA, 1);

`ifdef SP_COMMA_CNT_EN
    check("comma_cnt_small", {24'd0, comma_cnt_out}, 32'd1);
    repeat (300) send_byte(COMMA, 1);
    check("comma_cnt_sat", {24'd0, comma_cnt_out}, 32'hFF);
`endif

    send_bit(1'b0);
    send_bit(1'b0);
    check("sb_drained", sb_q.size(), 32'd0);
    check("strobe_count", n_strobes, n_pushed);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
